// File: rtl/cnn_stage_scheduler.sv
// cnn_stage_scheduler
//   Runtime-programmable sequencer for the CNN conv/ReLU/pool stage chain. Stages are
//   released from reset one at a time, in order. A stage ends on its own completion
//   strobe or when its latched cycle budget expires. start/busy/done handshake plus abort.
//
// Optional feature: define SCHED_PERF_EN to build the run cycle counter behind perf_cycles.
// Without it, perf_cycles is tied to zero.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-high
//   start          run request, only sampled in idle
//   abort          cancel the current run (wins over start)
//   stage_budget   per-stage cycle budget, stage i at [i*CNT_W +: CNT_W], latched on start
//   stage_done     per-stage early-completion strobe
//   stage_rst      1 = hold stage i in reset
//   stage_idx      active stage index (0 when not running)
//   busy           high from load through the last run cycle
//   done           one-cycle pulse on normal completion
//   timeout_flags  sticky, stage i ended by budget rather than by stage_done
//   perf_cycles    cycles from load through done (SCHED_PERF_EN only)
module cnn_stage_scheduler #(
    parameter int unsigned NUM_STAGES = 9,
    parameter int unsigned CNT_W      = 20,
    parameter int unsigned IDX_W      = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic [NUM_STAGES*CNT_W-1:0] stage_budget,
    input  logic [NUM_STAGES-1:0]       stage_done,
    output logic [NUM_STAGES-1:0]       stage_rst,
    output logic [IDX_W-1:0]            stage_idx,
    output logic                        busy,
    output logic                        done,
    output logic [NUM_STAGES-1:0]       timeout_flags,
    output logic [31:0]                 perf_cycles
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e                  state_q, state_d;
    logic [NUM_STAGES-1:0]   stage_rst_q, stage_rst_d;
    logic [IDX_W-1:0]        stage_idx_q, stage_idx_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [NUM_STAGES-1:0]   flags_q, flags_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        budget_q [NUM_STAGES];
    logic [CNT_W-1:0]        budget_d [NUM_STAGES];

    logic                    cur_done;
    logic                    cur_expired;
    logic                    is_last;
    logic [IDX_W-1:0]        idx_nxt;

    assign cur_done    = stage_done[stage_idx_q];
    assign cur_expired = (cnt_q >= budget_q[stage_idx_q]);
    assign is_last     = (stage_idx_q == IDX_W'(NUM_STAGES - 1));
    assign idx_nxt     = stage_idx_q + IDX_W'(1);

    always_comb begin
        state_d     = state_q;
        stage_rst_d = stage_rst_q;
        stage_idx_d = stage_idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        flags_d     = flags_q;
        cnt_d       = cnt_q;
        budget_d    = budget_q;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d     = StLoad;
                    busy_d      = 1'b1;
                    stage_rst_d = '1;
                    stage_idx_d = '0;
                    flags_d     = '0;
                    cnt_d       = '0;
                    // Latch on acceptance so budget changes after start never reach this run.
                    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                        budget_d[i] = stage_budget[i*CNT_W +: CNT_W];
                    end
                end
            end
            StLoad, StRun: begin
                if (abort) begin
                    // Partial timeout flags are kept for post-mortem.
                    state_d     = StIdle;
                    busy_d      = 1'b0;
                    stage_rst_d = '1;
                    stage_idx_d = '0;
                    cnt_d       = '0;
                end else if (state_q == StLoad) begin
                    state_d        = StRun;
                    stage_rst_d[0] = 1'b0;
                end else if (cur_done || cur_expired) begin
                    // stage_done beats budget expiry in the same cycle: no flag.
                    if (!cur_done) begin
                        flags_d[stage_idx_q] = 1'b1;
                    end
                    cnt_d = '0;
                    if (is_last) begin
                        state_d     = StDone;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        stage_rst_d = '0;
                        stage_idx_d = '0;
                    end else begin
                        // Earlier stages stay released so their outputs remain valid.
                        stage_idx_d          = idx_nxt;
                        stage_rst_d[idx_nxt] = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            stage_rst_q <= '1;
            stage_idx_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            flags_q     <= '0;
            cnt_q       <= '0;
            for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                budget_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            stage_rst_q <= stage_rst_d;
            stage_idx_q <= stage_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            flags_q     <= flags_d;
            cnt_q       <= cnt_d;
            budget_q    <= budget_d;
        end
    end

    assign stage_rst     = stage_rst_q;
    assign stage_idx     = stage_idx_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign timeout_flags = flags_q;

`ifdef SCHED_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Cleared on entry to load, then counts every load/run/done cycle, saturating.
    always_comb begin
        perf_d = perf_q;
        if (state_q == StIdle) begin
            if (start && !abort) begin
                perf_d = '0;
            end
        end else if (perf_q != '1) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule
